bin_alloc_ctrl: RTL and testbench

Allocation controller in front of the occupied-width RAM. It accepts one placement request at a time: an item width plus three candidate bin IDs in priority order. It reads the candidates' occupied widths from the RAM and picks the highest-priority bin with enough free capacity. It then commits the width back through the RAM write port and reports the chosen bin, or a failure, on a valid/ready response channel.

---
 rtl/bin_alloc_ctrl_if.sv | 24 ++
 rtl/bin_alloc_ctrl.sv | 136 +++++++++++++
 tb/tb_bin_alloc_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bin_alloc_ctrl_if.sv
// Request/response channel between a placement client and bin_alloc_ctrl.
// Carries the valid/ready handshakes plus the request and response payloads.
interface bin_alloc_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic [4:0] req_width;
    logic [3:0] req_id1;
    logic [3:0] req_id2;
    logic [3:0] req_id3;
    logic       resp_valid;
    logic       resp_ready;
    logic       resp_ok;
    logic [3:0] resp_id;

    modport slave (
        input  req_valid, req_width, req_id1, req_id2, req_id3, resp_ready,
        output req_ready, resp_valid, resp_ok, resp_id
    );

    modport master (
        output req_valid, req_width, req_id1, req_id2, req_id3, resp_ready,
        input  req_ready, resp_valid, resp_ok, resp_id
    );
endinterface

// File: rtl/bin_alloc_ctrl.sv
// Bin allocation controller: reads three candidate bins, picks the first
// one with room for the item, commits the width and reports the choice.
module bin_alloc_ctrl #(
    parameter int CAP    = 127,
    parameter int MAX_ID = 12
) (
    input  logic                   enclk,
    input  logic                   rst,
    bin_alloc_ctrl_if.slave        req_if,
    output logic                   ram_we,
    output logic [3:0]             ram_write_id,
    output logic [4:0]             ram_write_width,
    output logic [3:0]             ram_id1,
    output logic [3:0]             ram_id2,
    output logic [3:0]             ram_id3,
    input  logic [6:0]             ram_width1,
    input  logic [6:0]             ram_width2,
    input  logic [6:0]             ram_width3,
    output logic [7:0]             alloc_cnt,
    output logic [7:0]             fail_cnt
);
    localparam logic [7:0] CAP_W = 8'(CAP);
    localparam logic [3:0] MAX_W = 4'(MAX_ID);
    localparam logic [3:0] NO_ID = 4'd15;

    typedef enum logic [2:0] {
        IDLE, READ, EVAL, WRITE, RESP
    } state_t;

    state_t     state_q;
    logic [4:0] width_q;
    logic [3:0] id1_q, id2_q, id3_q;
    logic       we_q;
    logic [3:0] wr_id_q;
    logic [4:0] wr_width_q;
    logic       resp_valid_q;
    logic       resp_ok_q;
    logic [3:0] resp_id_q;
    logic [7:0] alloc_q, fail_q;

    logic [7:0] s1, s2, s3;
    logic       e1, e2, e3;
    logic       width_ok;
    logic       ok_d;
    logic [3:0] id_d;

    // Candidate eligibility; 8-bit sums so a 7-bit overflow never looks like a fit.
    always_comb begin
        s1 = {1'b0, ram_width1} + {3'b0, width_q};
        s2 = {1'b0, ram_width2} + {3'b0, width_q};
        s3 = {1'b0, ram_width3} + {3'b0, width_q};
        e1 = (id1_q <= MAX_W) && (s1 <= CAP_W);
        e2 = (id2_q <= MAX_W) && (s2 <= CAP_W);
        e3 = (id3_q <= MAX_W) && (s3 <= CAP_W);
        width_ok = (width_q >= 5'd4) && (width_q <= 5'd16);
        ok_d = width_ok && (e1 || e2 || e3);
        id_d = NO_ID;
        if (ok_d) begin
            if (e1)      id_d = id1_q;
            else if (e2) id_d = id2_q;
            else         id_d = id3_q;
        end
    end

    // Control FSM with registered outputs and saturating statistics.
    always_ff @(posedge enclk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            width_q      <= '0;
            id1_q        <= '0;
            id2_q        <= '0;
            id3_q        <= '0;
            we_q         <= 1'b0;
            wr_id_q      <= '0;
            wr_width_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_ok_q    <= 1'b0;
            resp_id_q    <= NO_ID;
            alloc_q      <= '0;
            fail_q       <= '0;
        end else begin
            we_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_if.req_valid) begin
                        width_q <= req_if.req_width;
                        id1_q   <= req_if.req_id1;
                        id2_q   <= req_if.req_id2;
                        id3_q   <= req_if.req_id3;
                        state_q <= READ;
                    end
                end
                READ: state_q <= EVAL;
                EVAL: begin
                    resp_ok_q <= ok_d;
                    resp_id_q <= id_d;
                    if (ok_d) begin
                        wr_id_q    <= id_d;
                        wr_width_q <= width_q;
                        we_q       <= 1'b1;
                        state_q    <= WRITE;
                    end else begin
                        resp_valid_q <= 1'b1;
                        if (fail_q != 8'hFF) fail_q <= fail_q + 8'd1;
                        state_q <= RESP;
                    end
                end
                WRITE: begin
                    resp_valid_q <= 1'b1;
                    if (alloc_q != 8'hFF) alloc_q <= alloc_q + 8'd1;
                    state_q <= RESP;
                end
                RESP: begin
                    if (req_if.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_if.req_ready  = (state_q == IDLE);
    assign req_if.resp_valid = resp_valid_q;
    assign req_if.resp_ok    = resp_ok_q;
    assign req_if.resp_id    = resp_id_q;
    assign ram_we            = we_q;
    assign ram_write_id      = wr_id_q;
    assign ram_write_width   = wr_width_q;
    assign ram_id1           = id1_q;
    assign ram_id2           = id2_q;
    assign ram_id3           = id3_q;
    assign alloc_cnt         = alloc_q;
    assign fail_cnt          = fail_q;
endmodule

// File: tb/tb_bin_alloc_ctrl.sv
// Directed testbench for bin_alloc_ctrl with a behavioural occupancy RAM.
// Expected values are hand-computed per scenario.
module tb_bin_alloc_ctrl;
    logic       enclk = 1'b0;
    logic       rst   = 1'b0;
    logic       ram_we;
    logic [3:0] ram_write_id;
    logic [4:0] ram_write_width;
    logic [3:0] ram_id1, ram_id2, ram_id3;
    logic [6:0] ram_width1, ram_width2, ram_width3;
    logic [7:0] alloc_cnt, fail_cnt;

    logic [6:0] mem [16];
    logic       ram_clr = 1'b0;
    logic       pre_en  = 1'b0;
    logic [3:0] pre_id  = '0;
    logic [6:0] pre_val = '0;

    int checks = 0;
    int errors = 0;
    int exp_alloc = 0;
    int exp_fail  = 0;

    bin_alloc_ctrl_if bus ();

    bin_alloc_ctrl dut (
        .enclk           (enclk),
        .rst             (rst),
        .req_if          (bus.slave),
        .ram_we          (ram_we),
        .ram_write_id    (ram_write_id),
        .ram_write_width (ram_write_width),
        .ram_id1         (ram_id1),
        .ram_id2         (ram_id2),
        .ram_id3         (ram_id3),
        .ram_width1      (ram_width1),
        .ram_width2      (ram_width2),
        .ram_width3      (ram_width3),
        .alloc_cnt       (alloc_cnt),
        .fail_cnt        (fail_cnt)
    );

    always #5 enclk = ~enclk;

    // Occupancy RAM: registered reads while not writing, additive writes.
    always @(posedge enclk) begin
        if (ram_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (pre_en) begin
            mem[pre_id] <= pre_val;
        end else if (ram_we) begin
            mem[ram_write_id] <= mem[ram_write_id] + 7'(ram_write_width);
        end
        if (!ram_we) begin
            ram_width1 <= mem[ram_id1];
            ram_width2 <= mem[ram_id2];
            ram_width3 <= mem[ram_id3];
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [3:0] id, input logic [6:0] val);
        @(negedge enclk);
        pre_en  = 1'b1;
        pre_id  = id;
        pre_val = val;
        @(negedge enclk);
        pre_en  = 1'b0;
    endtask

    // Issues one request and walks it to the first RESP cycle.
    task automatic do_req(input string tag, input logic [4:0] w,
                          input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input bit ok,
                          input logic [3:0] id);
        @(negedge enclk);
        chk({tag, ".ready"}, bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_width = w;
        bus.req_id1   = a;
        bus.req_id2   = b;
        bus.req_id3   = c;
        @(posedge enclk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_width = 5'd0;
        chk({tag, ".busy"}, bus.req_ready, 0);
        @(posedge enclk);
        #1;
        chk({tag, ".eval_we"}, ram_we, 0);
        @(posedge enclk);
        #1;
        if (ok) begin
            chk({tag, ".we"}, ram_we, 1);
            chk({tag, ".wid"}, ram_write_id, id);
            chk({tag, ".wwidth"}, ram_write_width, w);
            chk({tag, ".early_valid"}, bus.resp_valid, 0);
            @(posedge enclk);
            #1;
            exp_alloc++;
        end else begin
            exp_fail++;
        end
        chk({tag, ".valid"}, bus.resp_valid, 1);
        chk({tag, ".ok"}, bus.resp_ok, ok);
        chk({tag, ".id"}, bus.resp_id, id);
        chk({tag, ".we_off"}, ram_we, 0);
        chk({tag, ".alloc"}, alloc_cnt, exp_alloc);
        chk({tag, ".fail"}, fail_cnt, exp_fail);
    endtask

    task automatic end_resp(input string tag);
        @(negedge enclk);
        bus.resp_ready = 1'b1;
        @(posedge enclk);
        #1;
        chk({tag, ".idle"}, bus.req_ready, 1);
        chk({tag, ".vdone"}, bus.resp_valid, 0);
        @(negedge enclk);
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_width  = '0;
        bus.req_id1    = '0;
        bus.req_id2    = '0;
        bus.req_id3    = '0;
        bus.resp_ready = 1'b0;
        ram_clr = 1'b1;
        repeat (3) @(posedge enclk);
        #1;
        chk("rst.we", ram_we, 0);
        chk("rst.valid", bus.resp_valid, 0);
        chk("rst.ok", bus.resp_ok, 0);
        chk("rst.id", bus.resp_id, 15);
        chk("rst.wid", ram_write_id, 0);
        chk("rst.wwidth", ram_write_width, 0);
        chk("rst.rid1", ram_id1, 0);
        chk("rst.alloc", alloc_cnt, 0);
        chk("rst.fail", fail_cnt, 0);
        @(negedge enclk);
        ram_clr = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst.ready", bus.req_ready, 1);

        do_req("basic", 5'd10, 4'd1, 4'd2, 4'd3, 1'b1, 4'd1);
        end_resp("basic");
        chk("basic.mem1", mem[1], 10);

        preload(4'd4, 7'd120);
        do_req("skip", 5'd8, 4'd4, 4'd5, 4'd6, 1'b1, 4'd5);
        end_resp("skip");
        chk("skip.mem5", mem[5], 8);
        chk("skip.mem4", mem[4], 120);

        preload(4'd7, 7'd111);
        do_req("edge", 5'd16, 4'd7, 4'd13, 4'd13, 1'b1, 4'd7);
        end_resp("edge");
        chk("edge.mem7", mem[7], 127);
        do_req("full", 5'd16, 4'd7, 4'd13, 4'd13, 1'b0, 4'd15);
        end_resp("full");
        chk("full.mem7", mem[7], 127);

        do_req("w3", 5'd3, 4'd0, 4'd1, 4'd2, 1'b0, 4'd15);
        end_resp("w3");
        do_req("w17", 5'd17, 4'd0, 4'd1, 4'd2, 1'b0, 4'd15);
        end_resp("w17");
        chk("wbad.mem0", mem[0], 0);
        chk("wbad.mem1", mem[1], 10);
        chk("wbad.mem2", mem[2], 0);

        do_req("dup", 5'd5, 4'd2, 4'd2, 4'd3, 1'b1, 4'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge enclk);
            bus.req_valid = (i == 2);
            bus.req_width = 5'd9;
            bus.req_id1   = 4'd8;
            chk("hold.valid", bus.resp_valid, 1);
            chk("hold.ok", bus.resp_ok, 1);
            chk("hold.id", bus.resp_id, 2);
            chk("hold.ready", bus.req_ready, 0);
        end
        @(negedge enclk);
        bus.req_valid = 1'b0;
        end_resp("hold");
        repeat (4) begin
            @(posedge enclk);
            #1;
            chk("hold.idle", bus.req_ready, 1);
            chk("hold.nowe", ram_we, 0);
        end
        chk("hold.mem2", mem[2], 5);
        chk("hold.mem8", mem[8], 0);

        @(negedge enclk);
        bus.req_valid = 1'b1;
        bus.req_width = 5'd6;
        bus.req_id1   = 4'd3;
        bus.req_id2   = 4'd3;
        bus.req_id3   = 4'd3;
        @(posedge enclk);
        #1;
        bus.req_valid = 1'b0;
        repeat (2) @(posedge enclk);
        #1;
        chk("abort.we_pre", ram_we, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("abort.we", ram_we, 0);
        chk("abort.valid", bus.resp_valid, 0);
        chk("abort.ok", bus.resp_ok, 0);
        chk("abort.id", bus.resp_id, 15);
        chk("abort.wid", ram_write_id, 0);
        chk("abort.wwidth", ram_write_width, 0);
        chk("abort.alloc", alloc_cnt, 0);
        chk("abort.fail", fail_cnt, 0);
        chk("abort.ready", bus.req_ready, 1);
        repeat (2) @(posedge enclk);
        @(negedge enclk);
        rst = 1'b1;
        chk("abort.mem3", mem[3], 0);
        exp_alloc = 0;
        exp_fail  = 0;
        do_req("after", 5'd6, 4'd3, 4'd4, 4'd5, 1'b1, 4'd3);
        end_resp("after");
        chk("after.mem3", mem[3], 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
